// File: rtl/snn_pkg.sv
// Shared SNN definitions: leak modes, AER event type, sweep FSM states and
// the saturating potential update used by every block that touches a membrane.
package snn_pkg;

  localparam int LEAK_SUB   = 0;
  localparam int LEAK_SHIFT = 1;

  localparam int AER_IDX_W = 16;

  typedef struct packed {
    logic [AER_IDX_W-1:0] idx;
  } aer_evt_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } sweep_state_t;

  // A refractory counter must hold REFRACT itself; keep at least one bit.
  function automatic int refr_width(input int refract);
    return (refract > 0) ? $clog2(refract + 1) : 1;
  endfunction

  // Unsigned potential plus signed weight, clamped to [0, 2^width-1].
  // Evaluated with ample headroom so the sum can never wrap before the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0]        a,
                                          input logic signed [32:0] b,
                                          input int unsigned        width);
    logic signed [34:0] sum;
    logic signed [34:0] max_v;
    sum   = $signed({3'b000, a}) + 35'(b);
    max_v = $signed((35'(1) << width) - 35'(1));
    if (sum < 35'sd0) begin
      return 32'd0;
    end else if (sum > max_v) begin
      return 32'(max_v);
    end
    return 32'(sum);
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational per-neuron timestep update: refractory countdown, leak,
// threshold test and post-spike reset.
module lif_update
  import snn_pkg::*;
#(
  parameter int PW        = 16,
  parameter int THRESHOLD = 40000,
  parameter int LEAK_MODE = LEAK_SUB,
  parameter int LEAK      = 100,
  parameter int REFRACT   = 8,
  parameter int RW        = 4
) (
  input  logic [PW-1:0] i_pot,
  input  logic [RW-1:0] i_refr,
  output logic [PW-1:0] o_pot,
  output logic [RW-1:0] o_refr,
  output logic          o_spike
);

  localparam logic [PW-1:0] LEAK_V = PW'(LEAK);
  localparam logic [PW+1:0] THR_V  = (PW+2)'(THRESHOLD);

  logic [PW-1:0] w_leak;
  logic          w_fire;

  generate
    if (LEAK_MODE == LEAK_SHIFT) begin : g_leak_shift
      assign w_leak = i_pot - (i_pot >> LEAK);
    end else begin : g_leak_sub
      assign w_leak = (i_pot > LEAK_V) ? (i_pot - LEAK_V) : '0;
    end
  endgenerate

  assign w_fire = ({2'b00, w_leak} >= THR_V);

  always_comb begin
    o_pot   = i_pot;
    o_refr  = i_refr;
    o_spike = 1'b0;
    if (i_refr != '0) begin
      o_refr = i_refr - RW'(1);
    end else if (w_fire) begin
      o_pot   = '0;
      o_refr  = RW'(REFRACT);
      o_spike = 1'b1;
    end else begin
      o_pot = w_leak;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: synaptic events accumulate while idle,
// each tick sweeps every neuron through one shared update and emits AER spikes.
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int PW          = 16,
  parameter int THRESHOLD   = 40000,
  parameter int LEAK_MODE   = LEAK_SUB,
  parameter int LEAK        = 100,
  parameter int REFRACT     = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic signed [PW:0]   in_weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 sweep_done,
  output logic                 tick_overrun
);

  localparam int              RW   = refr_width(REFRACT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  sweep_state_t     r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_tick_pending;
  logic             r_tick_overrun;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_sweep_done;

  logic [PW-1:0]    w_pot  [NUM_NEURONS];
  logic [RW-1:0]    w_refr [NUM_NEURONS];

  logic             w_accept;
  logic             w_idx_ok;
  logic [PW-1:0]    w_evt_pot;
  logic [PW-1:0]    w_upd_pot;
  logic [RW-1:0]    w_upd_refr;
  logic             w_upd_spike;
  logic             w_stall;
  logic             w_advance;

  assign in_ready     = (r_state == S_IDLE) && !r_sweep_done;
  assign out_valid    = r_out_valid;
  assign out_idx      = r_out_idx;
  assign sweep_done   = r_sweep_done;
  assign tick_overrun = r_tick_overrun;

  assign w_accept  = in_valid && in_ready;
  assign w_idx_ok  = ({1'b0, in_idx} < (IDX_W+1)'(NUM_NEURONS));
  assign w_evt_pot = PW'(sat_add(32'(w_pot[in_idx]), 33'(in_weight), PW));

  lif_update #(
    .PW        (PW),
    .THRESHOLD (THRESHOLD),
    .LEAK_MODE (LEAK_MODE),
    .LEAK      (LEAK),
    .REFRACT   (REFRACT),
    .RW        (RW)
  ) u_update (
    .i_pot   (w_pot[r_ptr]),
    .i_refr  (w_refr[r_ptr]),
    .o_pot   (w_upd_pot),
    .o_refr  (w_upd_refr),
    .o_spike (w_upd_spike)
  );

  // Only a spike needs the output slot; quiet neurons keep flowing.
  assign w_stall   = (r_state == S_SWEEP) && w_upd_spike && r_out_valid && !out_ready;
  assign w_advance = (r_state == S_SWEEP) && !w_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
      logic [PW-1:0] r_pot;
      logic [RW-1:0] r_refr;
      logic          w_evt_we;
      logic          w_swp_we;

      // Events reaching a refractory neuron are consumed but have no effect.
      assign w_evt_we = w_accept && w_idx_ok && (in_idx == IDX_W'(gi)) && (r_refr == '0);
      assign w_swp_we = w_advance && (r_ptr == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pot  <= '0;
          r_refr <= '0;
        end else if (w_swp_we) begin
          r_pot  <= w_upd_pot;
          r_refr <= w_upd_refr;
        end else if (w_evt_we) begin
          r_pot  <= w_evt_pot;
        end
      end

      assign w_pot[gi]  = r_pot;
      assign w_refr[gi] = r_refr;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_tick_pending <= 1'b0;
      r_tick_overrun <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_idx      <= '0;
      r_sweep_done   <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (tick || r_tick_pending) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
            // A fresh tick arriving while a pending one is consumed is kept.
            r_tick_pending <= tick && r_tick_pending;
          end
        end
        S_SWEEP: begin
          if (tick) begin
            if (r_tick_pending) begin
              r_tick_overrun <= 1'b1;
            end else begin
              r_tick_pending <= 1'b1;
            end
          end
          if (!w_stall) begin
            if (w_upd_spike) begin
              r_out_valid <= 1'b1;
              r_out_idx   <= r_ptr;
            end
            if (r_ptr == LAST) begin
              r_sweep_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_ptr <= r_ptr + IDX_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
